// File: rtl/mod_start_seq_pkg.sv
// Shared types and constants for the start sequencer slice.
package mod_start_seq_pkg;

    // Sequencer phases: accept a request, run the downstream stage,
    // present the response, then wait for done to drop.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

    // Width of the completed-response counter.
    localparam int TXN_CNT_W = 8;

endpackage

// File: rtl/mod_start_sequencer_if.sv
// Request / start-done / response bundle of the start sequencer.
// Signal names are seen from the sequencer's side (i_ = into the sequencer).
interface mod_start_sequencer_if
    import mod_start_seq_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int LAT_W = 8
) ();

    logic                 i_req_valid;
    logic                 o_req_ready;
    logic [TAG_W-1:0]     i_req_tag;

    logic                 o_start;
    logic                 i_done;

    logic                 o_rsp_valid;
    logic                 i_rsp_ready;
    logic [TAG_W-1:0]     o_rsp_tag;
    logic [LAT_W-1:0]     o_rsp_lat;
    logic                 o_rsp_timeout;

    logic [TXN_CNT_W-1:0] o_txn_cnt;

    modport slave (
        input  i_req_valid, i_req_tag, i_done, i_rsp_ready,
        output o_req_ready, o_start, o_rsp_valid, o_rsp_tag, o_rsp_lat,
               o_rsp_timeout, o_txn_cnt
    );

    modport master (
        output i_req_valid, i_req_tag, i_done, i_rsp_ready,
        input  o_req_ready, o_start, o_rsp_valid, o_rsp_tag, o_rsp_lat,
               o_rsp_timeout, o_txn_cnt
    );

endinterface

// File: rtl/mod_start_sequencer_lat_timer.sv
// Latency counter for the ARM phase. Counts cycles without done; when the
// timeout is enabled it flags the last allowed cycle, otherwise it saturates.
module mod_seq_lat_timer #(
    parameter int LAT_W       = 8,
    parameter int TIMEOUT_CYC = 16,
    parameter bit TIMEOUT_EN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [LAT_W-1:0] count,
    output logic             expired
);

    localparam logic [LAT_W-1:0] CNT_MAX      = '1;
    localparam logic [LAT_W-1:0] TIMEOUT_LAST = LAT_W'(TIMEOUT_CYC - 1);

    assign expired = TIMEOUT_EN && (count == TIMEOUT_LAST);

    // Restart at zero on a new request, then count up without wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mod_start_sequencer.sv
// Start sequencer: takes one tagged request at a time, raises start to the
// downstream stage, measures how long done takes and reports tag/latency.
// Define MOD_START_SEQ_TIMEOUT_EN to abort ARM after TIMEOUT_CYC cycles.
module mod_start_sequencer
    import mod_start_seq_pkg::*;
#(
    parameter int TAG_W       = 4,
    parameter int LAT_W       = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    mod_start_sequencer_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ARM   = ARM;
    localparam logic [1:0] ST_RESP  = RESP;
    localparam logic [1:0] ST_DRAIN = DRAIN;

`ifdef MOD_START_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [TAG_W-1:0]     tag_q;
    logic                 req_ready_q;
    logic                 start_q;
    logic                 rsp_valid_q;
    logic [TAG_W-1:0]     rsp_tag_q;
    logic [LAT_W-1:0]     rsp_lat_q;
    logic [TXN_CNT_W-1:0] txn_cnt_q;
    logic [LAT_W-1:0]     lat_count;
    logic                 lat_expired;
    logic                 accept;
    logic                 arm_exit;
    logic                 count_en;

    assign accept   = (state == ST_IDLE) && req_ready_q && bus.i_req_valid;
    assign arm_exit = (state == ST_ARM) && (bus.i_done || lat_expired);
    assign count_en = (state == ST_ARM) && !bus.i_done;

    mod_seq_lat_timer #(
        .LAT_W       (LAT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TIMEOUT_EN  (TIMEOUT_EN)
    ) u_lat_timer (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clear   (accept),
        .enable  (count_en),
        .count   (lat_count),
        .expired (lat_expired)
    );

    // Next-state selection; done beats the timeout when both happen together.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)           state_nxt = ST_ARM;
            ST_ARM:   if (arm_exit)         state_nxt = ST_RESP;
            ST_RESP:  if (bus.i_rsp_ready)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (!bus.i_done)      state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    // State plus registered per-state outputs, so ready stays low through reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            req_ready_q <= (state_nxt == ST_IDLE);
            start_q     <= (state_nxt == ST_ARM);
            rsp_valid_q <= (state_nxt == ST_RESP);
        end
    end

    // Request tag is parked until ARM ends so response fields never move early.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_q     <= '0;
            rsp_tag_q <= '0;
            rsp_lat_q <= '0;
        end else begin
            if (accept) begin
                tag_q <= bus.i_req_tag;
            end
            if (arm_exit) begin
                rsp_tag_q <= tag_q;
                rsp_lat_q <= lat_count;
            end
        end
    end

    // Completed-response counter, wraps naturally at its width.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            txn_cnt_q <= '0;
        end else if ((state == ST_RESP) && bus.i_rsp_ready) begin
            txn_cnt_q <= txn_cnt_q + 1'b1;
        end
    end

`ifdef MOD_START_SEQ_TIMEOUT_EN
    logic rsp_timeout_q;

    // Leaving ARM without done can only mean the timer ran out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_timeout_q <= 1'b0;
        end else if (arm_exit) begin
            rsp_timeout_q <= !bus.i_done;
        end
    end

    assign bus.o_rsp_timeout = rsp_timeout_q;
`else
    assign bus.o_rsp_timeout = 1'b0;
`endif

    assign bus.o_req_ready = req_ready_q;
    assign bus.o_start     = start_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_tag   = rsp_tag_q;
    assign bus.o_rsp_lat   = rsp_lat_q;
    assign bus.o_txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_mod_start_sequencer.sv
// Self-checking bench for mod_start_sequencer (default or MOD_START_SEQ_TIMEOUT_EN build).
module tb_mod_start_sequencer;

    localparam int TAG_W       = 4;
    localparam int LAT_W       = 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int LAT_MAX     = (1 << LAT_W) - 1;
`ifdef MOD_START_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int PH_IDLE  = 0;
    localparam int PH_ARM   = 1;
    localparam int PH_RESP  = 2;
    localparam int PH_DRAIN = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic [TAG_W-1:0] req_tag;
    logic             loop_mode;
    logic             done_drv;
    logic             rsp_ready;

    int checks = 0;
    int errors = 0;

    mod_start_sequencer_if #(.TAG_W(TAG_W), .LAT_W(LAT_W)) bus ();

    assign bus.i_req_valid = req_valid;
    assign bus.i_req_tag   = req_tag;
    assign bus.i_rsp_ready = rsp_ready;
    assign bus.i_done      = loop_mode ? bus.o_start : done_drv;

    mod_start_sequencer #(
        .TAG_W       (TAG_W),
        .LAT_W       (LAT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int               m_phase;
    int               m_wait;
    int               m_lat;
    int               m_cnt;
    logic             m_ready;
    logic             m_start;
    logic             m_valid;
    logic             m_to;
    logic [TAG_W-1:0] m_tag;
    logic [TAG_W-1:0] m_pend;

    // Transaction-level reference: one request in flight, latency = cycles in ARM before done.
    always @(posedge clk or negedge rst_n) begin : model
        int               ph;
        int               w;
        int               lat;
        int               cnt;
        logic             to;
        logic             done_m;
        logic [TAG_W-1:0] tag;
        logic [TAG_W-1:0] pend;
        if (!rst_n) begin
            m_phase <= PH_IDLE;
            m_wait  <= 0;
            m_lat   <= 0;
            m_cnt   <= 0;
            m_ready <= 1'b0;
            m_start <= 1'b0;
            m_valid <= 1'b0;
            m_to    <= 1'b0;
            m_tag   <= '0;
            m_pend  <= '0;
        end else begin
            ph     = m_phase;
            w      = m_wait;
            lat    = m_lat;
            cnt    = m_cnt;
            to     = m_to;
            tag    = m_tag;
            pend   = m_pend;
            done_m = loop_mode ? m_start : done_drv;
            case (ph)
                PH_IDLE: begin
                    if (req_valid && m_ready) begin
                        pend = req_tag;
                        w    = 0;
                        ph   = PH_ARM;
                    end
                end
                PH_ARM: begin
                    if (done_m) begin
                        tag = pend; lat = w; to = 1'b0; ph = PH_RESP;
                    end else if (TO_EN && (w == TIMEOUT_CYC - 1)) begin
                        tag = pend; lat = w; to = 1'b1; ph = PH_RESP;
                    end else begin
                        w = (w < LAT_MAX) ? w + 1 : LAT_MAX;
                    end
                end
                PH_RESP: begin
                    if (rsp_ready) begin
                        cnt = (cnt + 1) % 256;
                        ph  = PH_DRAIN;
                    end
                end
                default: begin
                    if (!done_m) ph = PH_IDLE;
                end
            endcase
            m_phase <= ph;
            m_wait  <= w;
            m_lat   <= lat;
            m_cnt   <= cnt;
            m_to    <= to;
            m_tag   <= tag;
            m_pend  <= pend;
            m_ready <= (ph == PH_IDLE);
            m_start <= (ph == PH_ARM);
            m_valid <= (ph == PH_RESP);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [TAG_W-1:0] t,
                                 input logic lp, input logic d, input logic r);
        req_valid = v;
        req_tag   = t;
        loop_mode = lp;
        done_drv  = d;
        rsp_ready = r;
    endtask

    // sel 0 waits for o_start, sel 1 for o_rsp_valid
    task automatic waitFor(input int sel, input int max_cyc, input string name);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if ((sel == 0) ? bus.o_start : bus.o_rsp_valid) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=no_event required=event_within_%0d_cycles",
                 name, max_cyc);
    endtask

    // Every cycle: DUT outputs against the reference
    always @(negedge clk) begin
        checkOutput("cyc_req_ready",   32'(bus.o_req_ready),   32'(m_ready));
        checkOutput("cyc_start",       32'(bus.o_start),       32'(m_start));
        checkOutput("cyc_rsp_valid",   32'(bus.o_rsp_valid),   32'(m_valid));
        checkOutput("cyc_rsp_tag",     32'(bus.o_rsp_tag),     32'(m_tag));
        checkOutput("cyc_rsp_lat",     32'(bus.o_rsp_lat),     32'(m_lat));
        checkOutput("cyc_rsp_timeout", 32'(bus.o_rsp_timeout), 32'(m_to));
        checkOutput("cyc_txn_cnt",     32'(bus.o_txn_cnt),     32'(m_cnt));
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int hs;
        int cyc;
        logic seen;
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", 32'(bus.o_req_ready), 32'd0);
        checkOutput("reset_start",     32'(bus.o_start),     32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        checkOutput("reset_txn_cnt",   32'(bus.o_txn_cnt),   32'd0);
        checkOutput("reset_rsp_lat",   32'(bus.o_rsp_lat),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_ready", 32'(bus.o_req_ready), 32'd1);

        // Loopback, tag 5
        applyStimulus(1'b1, 4'h5, 1'b1, 1'b0, 1'b1);
        waitFor(0, 5, "lb_start");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        waitFor(1, 5, "lb_rsp");
        checkOutput("lb_tag", 32'(bus.o_rsp_tag),     32'h5);
        checkOutput("lb_lat", 32'(bus.o_rsp_lat),     32'd0);
        checkOutput("lb_to",  32'(bus.o_rsp_timeout), 32'd0);
        @(negedge clk);
        checkOutput("lb_cnt", 32'(bus.o_txn_cnt), 32'd1);
        repeat (2) @(negedge clk);

        // Done three cycles after start, then held into DRAIN
        applyStimulus(1'b1, 4'hA, 1'b0, 1'b0, 1'b1);
        waitFor(0, 5, "d3_start");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        waitFor(1, 5, "d3_rsp");
        checkOutput("d3_tag", 32'(bus.o_rsp_tag),     32'hA);
        checkOutput("d3_lat", 32'(bus.o_rsp_lat),     32'd3);
        checkOutput("d3_to",  32'(bus.o_rsp_timeout), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("drain_hold_ready", 32'(bus.o_req_ready), 32'd0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("drain_exit_ready", 32'(bus.o_req_ready), 32'd1);
        repeat (2) @(negedge clk);

        // Response back-pressure with a competing request
        applyStimulus(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
        waitFor(0, 5, "bp_start");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        waitFor(1, 5, "bp_rsp");
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", 32'(bus.o_rsp_valid), 32'd1);
            checkOutput("bp_tag",   32'(bus.o_rsp_tag),   32'h3);
            checkOutput("bp_lat",   32'(bus.o_rsp_lat),   32'd0);
            applyStimulus(1'b1, 4'hC, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("bp_cnt",       32'(bus.o_txn_cnt),   32'd3);
        checkOutput("bp_valid_off", 32'(bus.o_rsp_valid), 32'd0);
        checkOutput("bp_tag_hold",  32'(bus.o_rsp_tag),   32'h3);
        repeat (2) @(negedge clk);
        checkOutput("bp_ignored_ready", 32'(bus.o_req_ready), 32'd1);
        checkOutput("bp_ignored_start", 32'(bus.o_start),     32'd0);

        // Done never arrives
`ifdef MOD_START_SEQ_TIMEOUT_EN
        applyStimulus(1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
        waitFor(0, 5, "to_start");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        waitFor(1, 40, "to_rsp");
        checkOutput("to_tag", 32'(bus.o_rsp_tag),     32'h6);
        checkOutput("to_lat", 32'(bus.o_rsp_lat),     32'd15);
        checkOutput("to_to",  32'(bus.o_rsp_timeout), 32'd1);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 4'h9, 1'b0, 1'b0, 1'b1);
        waitFor(0, 5, "tie_start");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (15) @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        waitFor(1, 5, "tie_rsp");
        checkOutput("tie_lat", 32'(bus.o_rsp_lat),     32'd15);
        checkOutput("tie_to",  32'(bus.o_rsp_timeout), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
`else
        applyStimulus(1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
        waitFor(0, 5, "nto_start");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            seen = seen | bus.o_rsp_valid;
        end
        checkOutput("nto_no_valid", 32'(seen), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        waitFor(1, 5, "nto_rsp");
        checkOutput("nto_tag", 32'(bus.o_rsp_tag),     32'h6);
        checkOutput("nto_lat", 32'(bus.o_rsp_lat),     32'd255);
        checkOutput("nto_to",  32'(bus.o_rsp_timeout), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
`endif

        // Reset pulse in the middle of ARM
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
        waitFor(0, 5, "rst_start");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_start", 32'(bus.o_start),     32'd0);
        checkOutput("rst_async_valid", 32'(bus.o_rsp_valid), 32'd0);
        checkOutput("rst_async_cnt",   32'(bus.o_txn_cnt),   32'd0);
        checkOutput("rst_async_ready", 32'(bus.o_req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_rel_ready", 32'(bus.o_req_ready), 32'd1);
        applyStimulus(1'b1, 4'h7, 1'b1, 1'b0, 1'b1);
        waitFor(0, 5, "rst_next_start");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        waitFor(1, 5, "rst_next_rsp");
        checkOutput("rst_next_tag", 32'(bus.o_rsp_tag), 32'h7);
        checkOutput("rst_next_lat", 32'(bus.o_rsp_lat), 32'd0);
        @(negedge clk);
        checkOutput("rst_next_cnt", 32'(bus.o_txn_cnt), 32'd1);

        // Randomised traffic in blocks with different done behaviour
        for (int b = 0; b < 10; b++) begin
            logic lp;
            int   dprob;
            lp    = ($urandom_range(0, 3) == 0);
            dprob = ($urandom_range(0, 1) == 1) ? 2 : 20;
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                applyStimulus($urandom_range(0, 2) != 0, TAG_W'($urandom), lp,
                              $urandom_range(0, dprob - 1) == 0,
                              $urandom_range(0, 3) != 0);
            end
        end

        // 256 back-to-back loopback transactions from a clean counter
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 4'h1, 1'b1, 1'b0, 1'b1);
        hs  = 0;
        cyc = 0;
        while (hs < 256 && cyc < 1200) begin
            @(negedge clk);
            cyc++;
            if (bus.o_rsp_valid) begin
                hs++;
                if (hs == 256) begin
                    checkOutput("wrap_pre_cnt", 32'(bus.o_txn_cnt), 32'd255);
                    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
                end
            end
        end
        checkOutput("wrap_handshakes", 32'(hs), 32'd256);
        repeat (3) @(negedge clk);
        checkOutput("wrap_cnt", 32'(bus.o_txn_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
